// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Covers the hazards the EX forwarding unit cannot resolve: load-use stalls,
// taken-branch flushes and multi-cycle mult/div freezes (with a timeout).
// Control outputs are combinational from state + inputs; state and the
// saturating statistics counters are registered.
module hazard_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned TO_W       = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic [4:0]       ID_EX_rt,
    input  logic             ID_EX_memread,
    input  logic             EX_branch_tkn,
    input  logic             md_start,
    input  logic             md_done,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             EX_hold,
    output logic             EX_MEM_bubble,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic S_RUN     = 1'b0;
    localparam logic S_MD_WAIT = 1'b1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    logic             r_state;
    logic             w_state_nxt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [TO_W-1:0]  w_to_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_load_use;
    logic             w_flush_evt;

    // r0 is never a real load destination, so it cannot create a dependency.
    assign w_load_use = ID_EX_memread && (ID_EX_rt != 5'd0) &&
                        ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));

    // Decode hazard responses and next state from current state and inputs.
    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        EX_hold       = 1'b0;
        EX_MEM_bubble = 1'b0;
        md_err        = 1'b0;
        w_flush_evt   = 1'b0;
        w_state_nxt   = r_state;
        w_to_cnt_nxt  = r_to_cnt;

        if (rst_i) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (EX_branch_tkn) begin
                        // Branch wins: the wrong-path mult/div or load-use is squashed.
                        IF_ID_flush  = 1'b1;
                        ID_EX_bubble = 1'b1;
                        w_flush_evt  = 1'b1;
                    end else if (md_start && !md_done) begin
                        pc_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        EX_hold       = 1'b1;
                        EX_MEM_bubble = 1'b1;
                        w_state_nxt   = S_MD_WAIT;
                        w_to_cnt_nxt  = '0;
                    end else if (w_load_use) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                    end
                end
                default: begin
                    if (md_done) begin
                        w_state_nxt = S_RUN;
                    end else if (r_to_cnt == TO_LAST) begin
                        // Unit never answered: flag it and release the pipeline anyway.
                        md_err      = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        pc_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        EX_hold       = 1'b1;
                        EX_MEM_bubble = 1'b1;
                        w_to_cnt_nxt  = r_to_cnt + TO_W'(1);
                    end
                end
            endcase
        end
    end

    // State and timeout counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_RUN;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // Saturating stall and flush statistics.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed and random
// stimulus, predicts the response from a behavioural model and queues it; an
// independent monitor compares the DUT outputs against the queue each cycle.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MD_TO  = 8;
    localparam int unsigned TO_W   = 4;
    localparam int          SAT    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [6:0]       ctrl;
        logic [CNT_W-1:0] st;
        logic [CNT_W-1:0] fl;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [4:0]       IF_ID_rs = '0;
    logic [4:0]       IF_ID_rt = '0;
    logic [4:0]       ID_EX_rt = '0;
    logic             ID_EX_memread = 1'b0;
    logic             EX_branch_tkn = 1'b0;
    logic             md_start = 1'b0;
    logic             md_done = 1'b0;
    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             EX_hold;
    logic             EX_MEM_bubble;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    // Reference model state: multi-cycle unit busy, elapsed wait cycles, statistics.
    bit m_busy    = 1'b0;
    int m_waited  = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    hazard_ctrl #(
        .CNT_W      (CNT_W),
        .MD_TIMEOUT (MD_TO),
        .TO_W       (TO_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .IF_ID_rs      (IF_ID_rs),
        .IF_ID_rt      (IF_ID_rt),
        .ID_EX_rt      (ID_EX_rt),
        .ID_EX_memread (ID_EX_memread),
        .EX_branch_tkn (EX_branch_tkn),
        .md_start      (md_start),
        .md_done       (md_done),
        .pc_write      (pc_write),
        .IF_ID_write   (IF_ID_write),
        .IF_ID_flush   (IF_ID_flush),
        .ID_EX_bubble  (ID_EX_bubble),
        .EX_hold       (EX_hold),
        .EX_MEM_bubble (EX_MEM_bubble),
        .md_err        (md_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs at the falling edge and queue the prediction.
    task automatic cyc(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] xrt, input bit mr, input bit br,
                       input bit ms, input bit md);
        bit   pc, ifw, fls, bub, hold, exm, err;
        exp_t e;
        @(negedge clk_i);
        rst_i = r; IF_ID_rs = rs; IF_ID_rt = rt; ID_EX_rt = xrt;
        ID_EX_memread = mr; EX_branch_tkn = br; md_start = ms; md_done = md;
        pc = 1; ifw = 1; fls = 0; bub = 0; hold = 0; exm = 0; err = 0;
        if (r) begin
            m_busy = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
            pc = 0; ifw = 0;
        end else if (m_busy) begin
            if (md || m_waited == MD_TO - 1) begin
                err    = !md;
                m_busy = 0;
            end else begin
                pc = 0; ifw = 0; hold = 1; exm = 1;
                m_waited++;
            end
        end else if (br) begin
            fls = 1; bub = 1;
        end else if (ms && !md) begin
            pc = 0; ifw = 0; hold = 1; exm = 1;
            m_busy = 1; m_waited = 0;
        end else if (mr && xrt != 0 && (xrt == rs || xrt == rt)) begin
            pc = 0; ifw = 0; bub = 1;
        end
        e.ctrl = {pc, ifw, fls, bub, hold, exm, err};
        e.st   = CNT_W'(m_stalls);
        e.fl   = CNT_W'(m_flushes);
        q.push_back(e);
        if (!r && !pc) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
        if (!r && fls) m_flushes = (m_flushes < SAT) ? m_flushes + 1 : SAT;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs, then bubble has cleared memread
        cyc(0, 5, 0, 5, 1, 0, 0, 0);
        cyc(0, 5, 0, 0, 0, 0, 0, 0);
        // r0 never stalls; rt match stalls
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 5, 5, 1, 0, 0, 0);
        // branch beats md_start and load-use
        cyc(0, 5, 0, 5, 1, 1, 1, 0);
        idle(1);
        // md with done four cycles after start
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 3, 3, 3, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // zero-latency mult/div
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        // timeout with no done
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        idle(10);
        // reset in the middle of a wait
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // saturation of stall and flush counters
        for (int i = 0; i < 20; i++) cyc(0, 7, 0, 7, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(99) == 0),
                5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                $urandom_range(1) == 1, $urandom_range(7) == 0,
                $urandom_range(5) == 0,
                m_busy ? ($urandom_range(9) == 0) : ($urandom_range(3) == 0));
        end
        @(negedge clk_i);
        #3 done = 1'b1;
    end

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        logic [6:0] act;
        int budget = 0;
        while (!(done && q.size() == 0)) begin
            @(negedge clk_i);
            #2;
            budget++;
            if (budget > 5000) begin
                n_chk++; n_fail++;
                $display("FAIL budget: monitor ran %0d cycles, limit 5000", budget);
                break;
            end
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
                       EX_hold, EX_MEM_bubble, md_err};
                n_chk++;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl @%0t: got %b expected %b", $time, act, e.ctrl);
                end
                n_chk++;
                if (stall_cnt !== e.st) begin
                    n_fail++;
                    $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, e.st);
                end
                n_chk++;
                if (flush_cnt !== e.fl) begin
                    n_fail++;
                    $display("FAIL flush_cnt @%0t: got %0d expected %0d", $time, flush_cnt, e.fl);
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
